// File: rtl/gnrl_skid_stage.sv
// Two-entry valid/ready slice (main + skid) giving a full-throughput timing cut.
// i_rdy and o_vld are flop outputs; o_rdy never reaches i_rdy combinationally.
module gnrl_skid_stage #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  input  logic          flush,
  output logic [1:0]    occ
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          main_en, skid_en;
  logic          i_rdy_q, o_vld_q;
  logic          in_hs, out_hs;

  assign in_hs  = i_vld & i_rdy_q;
  assign out_hs = o_vld_q & o_rdy;

  // Next state plus load-enable/next-data for the two data registers
  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = i_dat;
    skid_d  = i_dat;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_hs) begin
            main_en = 1'b1;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_hs && out_hs) begin
            main_en = 1'b1;
          end else if (in_hs) begin
            skid_en = 1'b1;
            state_d = FULL;
          end else if (out_hs) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_hs) begin
            main_en = 1'b1;
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake flags are registered from the next state so both ports see flop outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      i_rdy_q <= 1'b0;
      o_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (main_en) main_q <= main_d;
      if (skid_en) skid_q <= skid_d;
      i_rdy_q <= (state_d != FULL);
      o_vld_q <= (state_d != EMPTY);
    end
  end

  assign i_rdy = i_rdy_q;
  assign o_vld = o_vld_q;
  assign o_dat = main_q;
  assign occ   = state_q;

endmodule

// File: tb/tb_gnrl_skid_stage.sv
// Bench for gnrl_skid_stage: directed scenarios plus random traffic, all checked
// against a queue model of held entries and a model of the registered ready flag.
module tb_gnrl_skid_stage;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_vld;
  logic          i_rdy;
  logic [DW-1:0] i_dat;
  logic          o_vld;
  logic          o_rdy;
  logic [DW-1:0] o_dat;
  logic          flush;
  logic [1:0]    occ;

  gnrl_skid_stage #(.DW(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .i_vld (i_vld),
    .i_rdy (i_rdy),
    .i_dat (i_dat),
    .o_vld (o_vld),
    .o_rdy (o_rdy),
    .o_dat (o_dat),
    .flush (flush),
    .occ   (occ)
  );

  always #5 clk = ~clk;

  int unsigned   n_tests = 0;
  int unsigned   n_fail  = 0;
  logic [DW-1:0] q[$];
  logic          m_rdy = 1'b0;
  logic          last_acc;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: held entries leave in acceptance order; ready is registered "fewer than two held"
  task automatic apply(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    logic ih, oh;
    i_vld = v; i_dat = d; o_rdy = r; flush = f;
    ih = v & m_rdy;
    oh = r & (q.size() != 0);
    @(posedge clk);
    #1;
    if (f) begin
      q.delete();
    end else begin
      if (oh) void'(q.pop_front());
      if (ih) q.push_back(d);
    end
    m_rdy    = (q.size() < 2);
    last_acc = ih & ~f;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic r);
    int unsigned tries = 0;
    last_acc = 1'b0;
    while (!last_acc) begin
      if (tries == 10) begin
        chk("send_timeout", 32'd0, 32'd1);
        return;
      end
      apply(1'b1, d, r, 1'b0);
      tries++;
    end
  endtask

  always @(negedge clk) begin
    chk("o_vld", {31'd0, o_vld}, {31'd0, q.size() != 0});
    chk("occ", {30'd0, occ}, q.size());
    chk("i_rdy", {31'd0, i_rdy}, {31'd0, m_rdy});
    if (o_vld && q.size() != 0) chk("o_dat", o_dat, q[0]);
  end

  initial begin
    logic          pv;
    logic [DW-1:0] pd;
    rst = 1'b1; i_vld = 1'b0; i_dat = '0; o_rdy = 1'b0; flush = 1'b0;
    #1;
    chk("rst_o_vld", {31'd0, o_vld}, 32'd0);
    chk("rst_i_rdy", {31'd0, i_rdy}, 32'd0);
    chk("rst_occ", {30'd0, occ}, 32'd0);
    chk("rst_o_dat", o_dat, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Not accepted at the first edge after release, accepted at the next
    i_vld = 1'b1; i_dat = 32'hA5A5_0001;
    chk("first_i_rdy", {31'd0, i_rdy}, 32'd0);
    apply(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    chk("first_not_acc_occ", {30'd0, occ}, 32'd0);
    chk("first_i_rdy_up", {31'd0, i_rdy}, 32'd1);
    apply(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    chk("first_o_vld", {31'd0, o_vld}, 32'd1);
    chk("first_o_dat", o_dat, 32'hA5A5_0001);
    chk("first_occ", {30'd0, occ}, 32'd1);
    apply(1'b0, '0, 1'b1, 1'b0);

    // Streaming
    for (int k = 0; k < 16; k++) begin
      apply(1'b1, k, 1'b1, 1'b0);
      chk("stream_o_dat", o_dat, k);
      chk("stream_occ", {30'd0, occ}, 32'd1);
      chk("stream_i_rdy", {31'd0, i_rdy}, 32'd1);
    end
    apply(1'b0, '0, 1'b1, 1'b0);

    // Back-pressure then release without bubbles
    apply(1'b1, 32'h11, 1'b0, 1'b0);
    apply(1'b1, 32'h22, 1'b0, 1'b0);
    apply(1'b1, 32'h33, 1'b0, 1'b0);
    chk("bp_occ", {30'd0, occ}, 32'd2);
    chk("bp_i_rdy", {31'd0, i_rdy}, 32'd0);
    chk("bp_head", o_dat, 32'h11);
    apply(1'b1, 32'h33, 1'b1, 1'b0);
    chk("bp_out2", o_dat, 32'h22);
    apply(1'b1, 32'h33, 1'b1, 1'b0);
    chk("bp_out3", o_dat, 32'h33);
    chk("bp_vld3", {31'd0, o_vld}, 32'd1);
    apply(1'b0, '0, 1'b1, 1'b0);
    chk("bp_empty", {30'd0, occ}, 32'd0);

    // Flush while full
    apply(1'b1, 32'h44, 1'b0, 1'b0);
    apply(1'b1, 32'h55, 1'b0, 1'b0);
    apply(1'b1, 32'h66, 1'b0, 1'b1);
    chk("fl_occ", {30'd0, occ}, 32'd0);
    chk("fl_o_vld", {31'd0, o_vld}, 32'd0);
    chk("fl_i_rdy", {31'd0, i_rdy}, 32'd1);
    apply(1'b0, '0, 1'b1, 1'b0);
    chk("fl_still_empty", {31'd0, o_vld}, 32'd0);

    // Asynchronous reset while full
    apply(1'b1, 32'h77, 1'b0, 1'b0);
    apply(1'b1, 32'h88, 1'b0, 1'b0);
    i_vld = 1'b0;
    #2 rst = 1'b1;
    q.delete(); m_rdy = 1'b0;
    #1;
    chk("arst_o_vld", {31'd0, o_vld}, 32'd0);
    chk("arst_i_rdy", {31'd0, i_rdy}, 32'd0);
    chk("arst_occ", {30'd0, occ}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    send(32'h5, 1'b1);
    chk("arst_out5", o_dat, 32'h5);
    send(32'h6, 1'b1);
    chk("arst_out6", o_dat, 32'h6);
    apply(1'b0, '0, 1'b1, 1'b0);

    // Random traffic; a refused offer is held with the same data
    pv = 1'b0; pd = '0;
    for (int n = 0; n < 10000; n++) begin
      logic          v, r, f;
      logic [DW-1:0] d;
      if (pv && !m_rdy) begin
        v = 1'b1; d = pd;
      end else begin
        v = $urandom_range(1); d = $urandom;
      end
      r = $urandom_range(1);
      f = ($urandom_range(63) == 0);
      apply(v, d, r, f);
      pv = v & ~last_acc & ~f;
      pd = d;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gnrl_skid_stage.md
Name: gnrl_skid_stage

Overview:
- Valid/ready pipeline slice with two entries: a main register and a skid register.
- Sits directly upstream of the team's load-enable DFF instances. It generates their load-enable and next-data, and decouples the ready path between producer and consumer.
- Sustains full throughput (one transfer per cycle). Both `i_rdy` and `o_vld` come straight from flops; there is no combinational path from `o_rdy` to `i_rdy`.
- Used wherever a timing cut is needed on a handshake bus.

Parameters:
- `DW`, 32, payload width in bits.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `i_vld`  input  1  upstream data valid.
- `i_rdy`  output  1  stage can accept; registered.
- `i_dat`  input  DW  upstream payload.
- `o_vld`  output  1  downstream data valid; registered.
- `o_rdy`  input  1  downstream accepts.
- `o_dat`  output  DW  downstream payload; registered, equals the main register.
- `flush`  input  1  synchronous discard of all held entries.
- `occ`  output  2  number of held entries, 0..2.

Behaviour:
- Handshake rules:
  - Input transfer (`in_hs`) occurs when `i_vld & i_rdy` at a rising edge.
  - Output transfer (`out_hs`) occurs when `o_vld & o_rdy` at a rising edge.
  - Upstream must hold `i_dat` stable while `i_vld & !i_rdy`. The stage holds `o_dat` stable while `o_vld & !o_rdy`.
- Reset (asynchronous on `rst` high, immediate):
  - `main_vld`, `skid_vld`, `i_rdy` and `o_vld` are 0.
  - Both data registers are 0, so `o_dat` = 0 and `occ` = 0.
  - `i_rdy` rises on the first rising edge after `rst` deasserts, so nothing is accepted during or at the release of reset.
- State machine (`occ` = state encoding):
  - EMPTY (0):
    - `in_hs` → main <= `i_dat`, go to ONE.
    - Otherwise stay in EMPTY.
  - ONE (1):
    - `in_hs & out_hs` → main <= `i_dat`, stay in ONE.
    - `in_hs` only → skid <= `i_dat`, go to FULL.
    - `out_hs` only → go to EMPTY.
    - Neither → hold.
  - FULL (2):
    - `i_rdy` = 0, so no `in_hs` is possible.
    - `out_hs` → main <= skid, go to ONE.
    - Otherwise hold.
- Registered outputs:
  - `o_vld` = `main_vld`.
  - `i_rdy` is registered as NOT(next `skid_vld`). It is 0 in FULL and 1 in EMPTY and ONE (after the first post-reset edge).
- Ordering: data leaves in acceptance order. The skid entry is always older than any later input.
- Data registers:
  - Load only on their enable conditions; otherwise hold.
  - Stale data may remain when the valid bit is 0, and downstream must ignore it.
- Latency: a value accepted at edge N is on `o_dat` with `o_vld` = 1 after edge N, i.e. in cycle N+1. Minimum latency is 1 cycle.
- Flush:
  - Highest priority except reset.
  - At the edge where `flush` = 1, next state is EMPTY and `i_rdy` = 1.
  - Any `in_hs` or `out_hs` in that cycle is discarded from the stage; the consumer still saw `o_dat`, so the producer treats it as consumed.
  - Data registers are not cleared.
- Simultaneous `flush` with `rst`: reset wins.
- Reset mid-operation: all held entries are lost, with no output glitch beyond the immediate clear of `o_vld`.
- Back-pressure:
  - `o_rdy` low for any number of cycles with `i_vld` high fills the stage to FULL within 2 accepts, then `i_rdy` drops.
  - No data is dropped or duplicated.

Test Plan:
- Reset then `i_vld` = 1 with `i_dat` = 0xA5A5_0001 at the first edge after release → not accepted (`i_rdy` = 0); accepted at the next edge; `o_vld` = 1 and `o_dat` = 0xA5A5_0001 one cycle later; `occ` = 1.
- Streaming: `o_rdy` held 1, 16 back-to-back inputs 0..15 → outputs 0..15 on 16 consecutive cycles; `occ` stays 1; `i_rdy` never drops.
- Back-pressure: `o_rdy` = 0, inputs 0x11, 0x22, 0x33 offered → 0x11 and 0x22 accepted, `i_rdy` = 0 and `occ` = 2. Then `o_rdy` = 1 → outputs 0x11, 0x22, 0x33 in order with no bubble between them after release.
- Flush in FULL: `occ` = 2, assert `flush` for one cycle with `i_vld` = 1 → next cycle `occ` = 0, `o_vld` = 0, `i_rdy` = 1; flushed and offered values never appear at the output.
- Async reset asserted mid-edge while `occ` = 2 → `o_vld`, `i_rdy` and `occ` go to 0 immediately without waiting for `clk`; after release, stream 0x5,0x6 → outputs exactly 0x5,0x6.
- Random `i_vld` / `o_rdy` (50%) over 10k cycles against a scoreboard FIFO → exact in-order match; `occ` always equals the scoreboard depth (≤2); no `o_dat` change while `o_vld & !o_rdy`.
